// File: rtl/fifo_param_umbral.sv
// fifo_param_umbral
//   Single-clock elastic buffer between the packet producer and consumer
//   stages. It has a generic data width and depth, programmable almost-full and
//   almost-empty thresholds, an occupancy count, and a sticky
//   overflow/underflow error flag with a clear input. A read and a write in the
//   same cycle are both accepted when the FIFO is full.
//
//   Build option:
//     FIFO_FWFT_EN  defined   -> first-word fall-through. data_out shows the
//                                head word combinationally, and
//                                valid_out = !empty.
//                   undefined -> registered read path with 1-cycle latency.
//
//   Ports:
//     clk, reset           rising-edge clock, synchronous active-high reset
//     write_enable         write request (data_in)
//     read_enable          read request
//     umbral_alto          almost_full  when count >= umbral_alto
//     umbral_bajo          almost_empty when count <= umbral_bajo
//     error_clr            clears the sticky error flag
//     data_out, valid_out  read data and its qualifier
//     full, empty          occupancy == DEPTH / occupancy == 0
//     almost_full/_empty   registered threshold flags
//     count                current occupancy (0..DEPTH)
//     wr_ptr, rd_ptr       write and read pointers (debug)
//     error                sticky overflow/underflow flag
module fifo_param_umbral #(
  parameter int TAMANO_DATOS     = 10,
  parameter int TAMANO_DIRECCION = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write_enable,
  input  logic                        read_enable,
  input  logic [TAMANO_DATOS-1:0]     data_in,
  input  logic [TAMANO_DIRECCION:0]   umbral_alto,
  input  logic [TAMANO_DIRECCION:0]   umbral_bajo,
  input  logic                        error_clr,
  output logic [TAMANO_DATOS-1:0]     data_out,
  output logic                        valid_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [TAMANO_DIRECCION:0]   count,
  output logic [TAMANO_DIRECCION-1:0] wr_ptr,
  output logic [TAMANO_DIRECCION-1:0] rd_ptr,
  output logic                        error
);

  localparam int DEPTH = 2 ** TAMANO_DIRECCION;
  localparam logic [TAMANO_DIRECCION:0] DEPTH_CNT = {1'b1, {TAMANO_DIRECCION{1'b0}}};

  logic [TAMANO_DATOS-1:0]   mem [DEPTH];
  logic                      rd_ok;
  logic                      wr_ok;
  logic                      fault;
  logic [TAMANO_DIRECCION:0] count_next;

  // A write into a full FIFO is accepted only when a read frees a slot in the
  // same cycle.
  always_comb begin
    rd_ok      = read_enable & ~empty;
    wr_ok      = write_enable & (~full | rd_ok);
    fault      = (write_enable & ~wr_ok) | (read_enable & ~rd_ok);
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = (TAMANO_DIRECCION+1)'(count + 1);
    else if (rd_ok && !wr_ok)
      count_next = (TAMANO_DIRECCION+1)'(count - 1);
  end

  // The storage array is not reset. Writes are blocked during a reset cycle.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok)
      mem[wr_ptr] <= data_in;
  end

  // The flags are registered from count_next, so they line up with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      error        <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= TAMANO_DIRECCION'(wr_ptr + 1);
      if (rd_ok)
        rd_ptr <= TAMANO_DIRECCION'(rd_ptr + 1);
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_CNT);
      almost_full  <= (count_next >= umbral_alto);
      almost_empty <= (count_next <= umbral_bajo);
      // A new fault wins over a simultaneous clear.
      error        <= (error & ~error_clr) | fault;
    end
  end

`ifdef FIFO_FWFT_EN
  // The head word is shown directly. The output is forced to zero while empty,
  // so uninitialised storage is never exposed.
  always_comb begin
    valid_out = ~empty;
    data_out  = empty ? '0 : mem[rd_ptr];
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (rd_ok) begin
      data_out  <= mem[rd_ptr];
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param_umbral.sv
module tb_fifo_param_umbral;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, write_enable, read_enable, error_clr;
  logic [DW-1:0] data_in, data_out;
  logic [AW:0]   umbral_alto, umbral_bajo, count;
  logic          valid_out, full, empty, almost_full, almost_empty, error;
  logic [AW-1:0] wr_ptr, rd_ptr;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard and reference model state
  logic [DW-1:0] sb [$];
  int            m_count;
  logic          m_err;
  logic [AW-1:0] m_wr, m_rd;
  logic [DW-1:0] exp_data;
  logic          exp_valid, exp_af, exp_ae;

  fifo_param_umbral #(.TAMANO_DATOS(DW), .TAMANO_DIRECCION(AW)) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
    .data_in(data_in), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .error_clr(error_clr), .data_out(data_out), .valid_out(valid_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .error(error)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, advance the model, then return 1 ns after the edge.
  task automatic drive(input logic rst, input logic we, input logic re,
                       input logic clr, input logic [DW-1:0] d);
    bit rd_ok, wr_ok, flt;
    reset = rst; write_enable = we; read_enable = re; error_clr = clr; data_in = d;
    if (rst) begin
      sb.delete();
      m_count = 0; m_err = 1'b0; m_wr = '0; m_rd = '0;
      exp_data = '0; exp_valid = 1'b0; exp_af = 1'b0; exp_ae = 1'b1;
    end else begin
      rd_ok = re && (m_count != 0);
      wr_ok = we && ((m_count != DEPTH) || rd_ok);
      flt   = (we && !wr_ok) || (re && !rd_ok);
`ifndef FIFO_FWFT_EN
      exp_valid = rd_ok;
      if (rd_ok) exp_data = sb.pop_front();
`else
      if (rd_ok) void'(sb.pop_front());
`endif
      if (rd_ok) m_rd = m_rd + 3'd1;
      if (wr_ok) begin
        sb.push_back(d);
        m_wr = m_wr + 3'd1;
      end
      m_count = m_count + int'(wr_ok) - int'(rd_ok);
      m_err   = (m_err && !clr) || flt;
      exp_af  = m_count >= int'(umbral_alto);
      exp_ae  = m_count <= int'(umbral_bajo);
    end
`ifdef FIFO_FWFT_EN
    exp_valid = (sb.size() != 0);
    exp_data  = exp_valid ? sb[0] : '0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        count !== 4'd0 || error !== 1'b0 || data_out !== 10'h000 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: empty=%b ae=%b full=%b af=%b count=%0d err=%b data=%h valid=%b want 1 1 0 0 0 0 000 0",
               empty, almost_empty, full, almost_full, count, error, data_out, valid_out);
    end
    n_vec++;
    if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
      n_err++;
      $display("FAIL reset_ptrs: wr=%0d rd=%0d want 0 0", wr_ptr, rd_ptr);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
      n_vec++;
      if (count !== 4'(i) || almost_empty !== (i <= 2) || almost_full !== (i >= 6) ||
          full !== (i == 8) || empty !== 1'b0 || error !== 1'b0) begin
        n_err++;
        $display("FAIL fill[%0d]: count=%0d ae=%b af=%b full=%b empty=%b err=%b want %0d %b %b %b 0 0",
                 i, count, almost_empty, almost_full, full, empty, error,
                 i, (i <= 2), (i >= 6), (i == 8));
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF);
    n_vec++;
    if (error !== 1'b1 || count !== 4'd8 || wr_ptr !== 3'd0 || full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: err=%b count=%0d wr_ptr=%0d full=%b want 1 8 0 1", error, count, wr_ptr, full);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    n_vec++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_clr: err=%b want 0", error);
    end
  endtask

  task automatic test_full_rw();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 10'h055);
    n_vec++;
    if (count !== 4'd8 || full !== 1'b1 || error !== 1'b0) begin
      n_err++;
      $display("FAIL full_rw_flags: count=%0d full=%b err=%b want 8 1 0", count, full, error);
    end
    n_vec++;
    if (valid_out !== exp_valid || data_out !== exp_data) begin
      n_err++;
      $display("FAIL full_rw_data: data=%h valid=%b want %h %b", data_out, valid_out, exp_data, exp_valid);
    end
`ifndef FIFO_FWFT_EN
    n_vec++;
    if (data_out !== 10'h001 || valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL full_rw_first: data=%h valid=%b want 001 1", data_out, valid_out);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
      n_vec++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data) || count !== 4'(m_count)) begin
        n_err++;
        $display("FAIL drain[%0d]: data=%h valid=%b count=%0d want %h %b %0d",
                 i, data_out, valid_out, count, exp_data, exp_valid, m_count);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    n_vec++;
    if (error !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL underflow: err=%b count=%0d empty=%b want 1 0 1", error, count, empty);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    n_vec++;
    if (error !== 1'b0) begin
      n_err++;
      $display("FAIL underflow_clr: err=%b want 0", error);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 10'h123);
    n_vec++;
    if (count !== 4'd1 || error !== 1'b1 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL empty_rw: count=%0d err=%b empty=%b want 1 1 0", count, error, empty);
    end
  endtask

  task automatic test_thresholds();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    umbral_alto = 4'd0; umbral_bajo = 4'd8;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL thr_empty: af=%b ae=%b want 1 1", almost_full, almost_empty);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
    n_vec++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b1) begin
      n_err++;
      $display("FAIL thr_full: af=%b ae=%b full=%b want 1 1 1", almost_full, almost_empty, full);
    end
    umbral_alto = 4'd6; umbral_bajo = 4'd2;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
      n_err++;
      $display("FAIL thr_restore: af=%b ae=%b want 1 0", almost_full, almost_empty);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(10'h200 + i));
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(10'h100 + i));
      else            drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
      n_vec++;
      if (wr_ptr !== m_wr || rd_ptr !== m_rd || count !== 4'(m_count) ||
          count < 4'd3 || count > 4'd5 || error !== 1'b0 ||
          valid_out !== exp_valid || (exp_valid && data_out !== exp_data)) begin
        n_err++;
        $display("FAIL wrap[%0d]: wr=%0d rd=%0d count=%0d err=%b data=%h valid=%b want %0d %0d %0d 0 %h %b",
                 i, wr_ptr, rd_ptr, count, error, data_out, valid_out,
                 m_wr, m_rd, m_count, exp_data, exp_valid);
      end
    end
    n_vec++;
    if (wr_ptr !== 3'd5 || rd_ptr !== 3'd2) begin
      n_err++;
      $display("FAIL wrap_ptrs: wr=%0d rd=%0d want 5 2", wr_ptr, rd_ptr);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF);
    n_vec++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || error !== 1'b0 || data_out !== 10'h000 || valid_out !== 1'b0 ||
        wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
      n_err++;
      $display("FAIL mid_reset: count=%0d empty=%b full=%b ae=%b af=%b err=%b data=%h valid=%b wr=%0d rd=%0d",
               count, empty, full, almost_empty, almost_full, error, data_out, valid_out, wr_ptr, rd_ptr);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h0AA);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
`ifndef FIFO_FWFT_EN
    n_vec++;
    if (data_out !== 10'h0AA || valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_read: data=%h valid=%b want 0aa 1", data_out, valid_out);
    end
`else
    n_vec++;
    if (empty !== 1'b1 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_read: empty=%b valid=%b want 1 0", empty, valid_out);
    end
`endif
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h2A5);
    n_vec++;
    if (data_out !== 10'h2A5 || valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL fwft_show: data=%h valid=%b want 2a5 1", data_out, valid_out);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    n_vec++;
    if (empty !== 1'b1 || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL fwft_pop: empty=%b valid=%b want 1 0", empty, valid_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_drain();
    test_thresholds();
    test_wrap();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
